// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Data-memory bus between the load/store unit (master) and the data memory
// (slave). Word-addressed, byte-enabled, with a single ready handshake.
//   dmem_req    master->slave  request valid
//   dmem_we     master->slave  request is a write
//   dmem_addr   master->slave  word address (byte address [31:2])
//   dmem_be     master->slave  byte enables, bit i = byte lane i
//   dmem_wdata  master->slave  lane-replicated write data
//   dmem_ready  slave->master  request accepted this cycle
//   dmem_rdata  slave->master  read word, valid the cycle after an accepted read
// -----------------------------------------------------------------------------
interface load_store_unit_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [29:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Data-memory access stage between s2 (memory) and s3 (write-back). Drives the
// data memory from the s2 access, holds the request while the memory is not
// ready (raising lsu_stall), and returns aligned, extended load data one cycle
// after the read is accepted.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   acc_valid/we      s2 access present / access is a store
//   acc_addr          byte address
//   acc_size          00 byte, 01 half, 1x word
//   acc_unsigned      loads: 1 zero-extend, 0 sign-extend
//   store_data        store operand
//   dmem              data-memory bus (load_store_unit_if.master)
//   load_valid        load_data newly formed this cycle
//   load_data         extended load result, held between loads
//   lsu_stall         freeze s2 and earlier stages
//   misaligned        one-cycle pulse on a trapped misaligned access
//
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (no memory request, load returns 0). Otherwise misaligned accesses
// are aligned down and misaligned stays 0.
// -----------------------------------------------------------------------------
module load_store_unit (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     acc_valid,
   input  logic                     acc_we,
   input  logic [31:0]              acc_addr,
   input  logic [1:0]               acc_size,
   input  logic                     acc_unsigned,
   input  logic [31:0]              store_data,
   load_store_unit_if.master        dmem,
   output logic                     load_valid,
   output logic [31:0]              load_data,
   output logic                     lsu_stall,
   output logic                     misaligned
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state, state_nxt;

   // held request while the memory is not ready
   logic [29:0] req_addr;
   logic        req_we;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_uns;
   logic [1:0]  req_lane;

   // read response bookkeeping for the cycle after acceptance
   logic        pend;
   logic        pend_zero;
   logic [1:0]  pend_size;
   logic        pend_uns;
   logic [1:0]  pend_lane;
   logic [31:0] load_data_q;

   logic [3:0]  acc_be;
   logic [31:0] acc_wdata;
   logic        acc_mis;
   logic        issue_new;
   logic        trap_load;
   logic [1:0]  rsp_size;
   logic        rsp_uns;
   logic [1:0]  rsp_lane;
   logic [31:0] byte_sh;
   logic [31:0] half_sh;
   logic [31:0] formed;

   always_comb begin
      acc_be    = 4'b1111;
      acc_wdata = store_data;
      unique case (acc_size)
         2'b00: begin
            acc_be    = 4'b0001 << acc_addr[1:0];
            acc_wdata = {4{store_data[7:0]}};
         end
         2'b01: begin
            acc_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
            acc_wdata = {2{store_data[15:0]}};
         end
         default: ;
      endcase
`ifdef LSU_MISALIGN_TRAP_EN
      acc_mis = ((acc_size == 2'b01) && acc_addr[0]) ||
                (acc_size[1] && (acc_addr[1:0] != 2'b00));
`else
      acc_mis = 1'b0;
`endif
   end

   always_comb begin
      state_nxt       = state;
      dmem.dmem_req   = 1'b0;
      dmem.dmem_we    = 1'b0;
      dmem.dmem_addr  = '0;
      dmem.dmem_be    = '0;
      dmem.dmem_wdata = '0;
      lsu_stall       = 1'b0;
      misaligned      = 1'b0;
      issue_new       = 1'b0;
      unique case (state)
         IDLE: begin
            if (acc_valid) begin
               if (acc_mis) begin
                  misaligned = 1'b1;
               end else begin
                  issue_new       = 1'b1;
                  dmem.dmem_req   = 1'b1;
                  dmem.dmem_we    = acc_we;
                  dmem.dmem_addr  = acc_addr[31:2];
                  dmem.dmem_be    = acc_be;
                  dmem.dmem_wdata = acc_wdata;
                  if (!dmem.dmem_ready) begin
                     lsu_stall = 1'b1;
                     state_nxt = WAIT;
                  end
               end
            end
         end
         WAIT: begin
            dmem.dmem_req   = 1'b1;
            dmem.dmem_we    = req_we;
            dmem.dmem_addr  = req_addr;
            dmem.dmem_be    = req_be;
            dmem.dmem_wdata = req_wdata;
            if (dmem.dmem_ready) state_nxt = IDLE;
            else                 lsu_stall = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // response attributes come from whichever source is driving the bus
   always_comb begin
      rsp_size  = (state == WAIT) ? req_size : acc_size;
      rsp_uns   = (state == WAIT) ? req_uns  : acc_unsigned;
      rsp_lane  = (state == WAIT) ? req_lane : acc_addr[1:0];
      trap_load = misaligned && !acc_we;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         req_addr    <= '0;
         req_we      <= 1'b0;
         req_be      <= '0;
         req_wdata   <= '0;
         req_size    <= '0;
         req_uns     <= 1'b0;
         req_lane    <= '0;
         pend        <= 1'b0;
         pend_zero   <= 1'b0;
         pend_size   <= '0;
         pend_uns    <= 1'b0;
         pend_lane   <= '0;
         load_data_q <= '0;
      end else begin
         state <= state_nxt;
         if (issue_new && !dmem.dmem_ready) begin
            req_addr  <= acc_addr[31:2];
            req_we    <= acc_we;
            req_be    <= acc_be;
            req_wdata <= acc_wdata;
            req_size  <= acc_size;
            req_uns   <= acc_unsigned;
            req_lane  <= acc_addr[1:0];
         end
         pend      <= (dmem.dmem_req && dmem.dmem_ready && !dmem.dmem_we) || trap_load;
         pend_zero <= trap_load;
         pend_size <= rsp_size;
         pend_uns  <= rsp_uns;
         pend_lane <= rsp_lane;
         if (pend) load_data_q <= formed;
      end
   end

   // half-word selection uses lane bit 1 only so unaligned halves align down
   always_comb begin
      byte_sh = dmem.dmem_rdata >> {pend_lane, 3'b000};
      half_sh = dmem.dmem_rdata >> {pend_lane[1], 4'b0000};
      unique case (pend_size)
         2'b00:   formed = {{24{!pend_uns && byte_sh[7]}}, byte_sh[7:0]};
         2'b01:   formed = {{16{!pend_uns && half_sh[15]}}, half_sh[15:0]};
         default: formed = dmem.dmem_rdata;
      endcase
      if (pend_zero) formed = '0;
      load_valid = pend;
      load_data  = pend ? formed : load_data_q;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage between the pipeline's s2 (memory) and s3 (register write-back) stages. Takes the ALU-computed address, store data and access size from s2; drives a word-addressed, byte-enabled data memory with a ready handshake; and returns aligned, sign- or zero-extended load data in time for s3 write-back. Raises a stall while the memory is not ready so the pipeline freezes.

## Interface
Parameters:
- None.

Ports:
- `clk` in 1: pipeline clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `acc_valid` in 1: s2 carries a memory access (microcode alu_out_to_mem_addr).
- `acc_we` in 1: access is a store (microcode mem_we); 0 = load.
- `acc_addr` in 32: byte address from ALU output.
- `acc_size` in 2: 00 byte, 01 half, 10 word; 11 treated as word.
- `acc_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `store_data` in 32: register-file B port value.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: request is a write.
- `dmem_addr` out 30: word address (`acc_addr[31:2]`).
- `dmem_be` out 4: byte enables, bit i = byte lane i.
- `dmem_wdata` out 32: lane-replicated write data.
- `dmem_ready` in 1: memory accepts the request this cycle.
- `dmem_rdata` in 32: read word, valid the cycle after an accepted read.
- `load_valid` out 1: `load_data` is newly formed this cycle.
- `load_data` out 32: extended load result; holds the last value otherwise.
- `lsu_stall` out 1: freeze s2 and all earlier stages.
- `misaligned` out 1: one-cycle pulse on a misaligned access (see Configuration).

## Operation
- States: IDLE, WAIT.
- IDLE: `dmem_*` are driven combinationally from `acc_*` when `acc_valid`.
  - If `dmem_ready` is high, the request is accepted; stay in IDLE.
  - If `dmem_ready` is low, capture address, we, be, wdata, size, unsigned and lane into request registers and go to WAIT.
- WAIT: `dmem_*` are driven from the request registers with `dmem_req` = 1; `acc_*` are ignored. Return to IDLE on `dmem_ready`.
- `lsu_stall` = (IDLE & `acc_valid` & ~`dmem_ready`) | (WAIT & ~`dmem_ready`). It is combinational.
- Byte enables (lane = `addr[1:0]`):
  - byte: `be` = 1 << lane; `wdata` = {4{`store_data[7:0]`}}.
  - half: `be` = `addr[1]` ? 1100 : 0011; `wdata` = {2{`store_data[15:0]`}}.
  - word: `be` = 1111; `wdata` = `store_data`.
  - Loads drive the same `be`. `dmem_we` = 0 for loads.
- Read response:
  - On acceptance of a read, register pending = 1 plus size, unsigned and lane.
  - Next cycle: `load_valid` = 1 and `load_data` = selected byte or half from `dmem_rdata`, shifted down, extended per `acc_unsigned`. Word passes through.
  - The formed value is captured into `load_data_q`. When `load_valid` = 0, `load_data` = `load_data_q`.
- Stores produce no `load_valid`.
- Reset: state IDLE, pending 0, request registers 0, `load_data_q` 0.
  - Outputs after reset with `acc_valid` = 0: `dmem_req` 0, `dmem_we` 0, `dmem_addr` 0, `dmem_be` 0, `dmem_wdata` 0, `load_valid` 0, `load_data` 0, `lsu_stall` 0, `misaligned` 0.
  - Reset in WAIT abandons the request. `dmem_req` drops in the cycle after the reset edge.

## Timing
- Zero-wait memory: request in cycle N (s2), `load_valid` and data in N+1 (s3). No stall.
- k wait cycles: `lsu_stall` is high in cycles N..N+k-1, ready arrives at N+k, data at N+k+1.
- Back-to-back accesses: a new access may be accepted in the same cycle a prior read's data returns. `load_valid` belongs to the prior read.
- `dmem_ready` while `dmem_req` = 0 is ignored.
- Address width rule: bits [1:0] select the lane only. `dmem_addr` never wraps or increments.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned = half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
  - For such an access: `dmem_req` stays 0, `misaligned` pulses in the access cycle, and `lsu_stall` = 0.
  - For a load, `load_valid` pulses the next cycle with `load_data` = 0.
- Undefined: `misaligned` is tied 0. Half uses `addr[1]` only and word ignores `addr[1:0]`, so misaligned accesses are silently aligned down.

## Test plan
- Store byte 0xA5 to 0x1003, ready = 1 -> `dmem_addr` 0x400, `be` 1000, `wdata` 0xA5A5A5A5, `we` 1, no stall.
- `dmem_rdata` 0x80FF1234, load signed byte at 0x...2 -> next cycle `load_valid` 1, `load_data` 0xFFFFFFFF. The same read as unsigned half at 0x...2 -> 0x000080FF.
- Load word, `dmem_ready` low 3 cycles -> `lsu_stall` high 3 cycles with `dmem_*` stable from the latched values while `acc_*` change. Data one cycle after ready.
- Reset asserted in WAIT -> next cycle `dmem_req` 0, `lsu_stall` 0, `load_data` 0.
- Load at 0x10 then store at 0x14, both accepted back-to-back -> load data appears in the store's cycle and the store is issued unaffected.
- With `LSU_MISALIGN_TRAP_EN`, load word at 0x102 -> `misaligned` 1, `dmem_req` 0, then `load_valid` 1 with `load_data` 0. Without the macro -> `dmem_addr` 0x40, `be` 1111.
